// File: rtl/pc_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit_if
//   Instruction-memory request/response bundle between the fetch sequencer
//   and instruction memory.
//
//   imem_req     fetch side -> memory : request valid
//   imem_addr    fetch side -> memory : word-aligned request address
//   imem_gnt     memory -> fetch side : request accepted this cycle
//   imem_rvalid  memory -> fetch side : response valid (one per grant)
//   imem_rdata   memory -> fetch side : response instruction word
//
//   master : fetch sequencer view
//   slave  : instruction memory view
// ----------------------------------------------------------------------------
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//   Instruction-fetch sequencer. Holds the fetch PC, issues one outstanding
//   word request at a time to instruction memory, and presents the fetched
//   instruction to IF/ID with a valid/stall hold. Branch (pc_sel) and jump
//   redirects reload the PC, discard any in-flight response and flush the
//   front end.
//
//   clk                in  : clock, rising edge
//   reset_n            in  : asynchronous active-low reset
//   pc_sel             in  : branch taken, redirect to branch_target
//   branch_target      in  : branch destination
//   jump               in  : jal/jalr, redirect to jump_target
//   jump_target        in  : jump destination
//   stall              in  : decode cannot accept, hold presented instruction
//   imem               if  : instruction-memory req/gnt/rvalid bundle (master)
//   inst_valid         out : inst/inst_pc valid to IF/ID
//   inst               out : fetched instruction
//   inst_pc            out : address of inst
//   flush              out : kill IF/ID and ID/EX (combinational redirect)
//   target_misaligned  out : registered 1-cycle pulse, redirect target [1:0]!=0
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_REQ  | request driven at pc, waiting for grant
//   S_RSP  | request granted, waiting for rvalid (drop_q marks a discard)
//   S_HOLD | instruction presented to IF/ID, held while stall is high
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  pc_sel,
    input  logic [XLEN-1:0]       branch_target,
    input  logic                  jump,
    input  logic [XLEN-1:0]       jump_target,
    input  logic                  stall,

    pc_fetch_unit_if.master       imem,

    output logic                  inst_valid,
    output logic [31:0]           inst,
    output logic [XLEN-1:0]       inst_pc,
    output logic                  flush,
    output logic                  target_misaligned
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RSP  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0]     NOP_INST  = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_PCA = {RESET_PC[XLEN-1:2], 2'b00};

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic            misaligned_q, misaligned_d;

    logic            redirect;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_inc;

    // Branch wins over jump when both fire in the same cycle.
    assign redirect   = pc_sel | jump;
    assign target_raw = pc_sel ? branch_target : jump_target;
    assign target     = {target_raw[XLEN-1:2], 2'b00};
    assign pc_inc     = pc_q + PC_STEP;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PCA;
            drop_q       <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        misaligned_d = redirect && (target_raw[1:0] != 2'b00);

        case (state_q)
            S_REQ: begin
                // rvalid here can only be a stale response (e.g. after reset);
                // it is ignored.
                if (imem.imem_gnt) begin
                    state_d = S_RSP;
                    drop_d  = redirect;
                end
                if (redirect) begin
                    pc_d = target;
                end
            end

            S_RSP: begin
                if (imem.imem_rvalid) begin
                    if (drop_q || redirect) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                        if (redirect) begin
                            pc_d = target;
                        end
                    end else begin
                        inst_d       = imem.imem_rdata;
                        inst_pc_d    = pc_q;
                        pc_d         = pc_inc;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (redirect) begin
                    // Response is still owed by memory; remember to discard it.
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    inst_valid_d = 1'b0;
                    pc_d         = target;
                    state_d      = S_REQ;
                end else if (!stall) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end

            default: begin
                state_d      = S_REQ;
                drop_d       = 1'b0;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    assign imem.imem_req     = (state_q == S_REQ);
    assign imem.imem_addr    = pc_q;

    assign inst_valid        = inst_valid_q;
    assign inst              = inst_q;
    assign inst_pc           = inst_pc_q;
    assign flush             = redirect;
    assign target_misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset_n;
    logic            pc_sel;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            stall;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            flush;
    logic            target_misaligned;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit_if #(.XLEN(XLEN)) imem ();

    pc_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pc_sel            (pc_sel),
        .branch_target     (branch_target),
        .jump              (jump),
        .jump_target       (jump_target),
        .stall             (stall),
        .imem              (imem.master),
        .inst_valid        (inst_valid),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .flush             (flush),
        .target_misaligned (target_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word at address a is a ^ 32'hA500_0013.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA500_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One zero-wait fetch starting in REQ; ends in REQ after a consuming cycle.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] exp_inst);
        chk("fetch_req", 32'(imem.imem_req), 32'd1);
        chk("fetch_addr", imem.imem_addr, exp_addr);
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        chk("fetch_rsp_req", 32'(imem.imem_req), 32'd0);
        chk("fetch_rsp_valid", 32'(inst_valid), 32'd0);
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = mem_word(exp_addr);
        tick();
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        chk("fetch_valid", 32'(inst_valid), 32'd1);
        chk("fetch_inst", inst, exp_inst);
        chk("fetch_inst_pc", inst_pc, exp_addr);
        tick();
        chk("fetch_valid_drop", 32'(inst_valid), 32'd0);
    endtask

    initial begin
        reset_n          = 1'b0;
        pc_sel           = 1'b0;
        branch_target    = '0;
        jump             = 1'b0;
        jump_target      = '0;
        stall            = 1'b0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;

        // Reset values
        #12;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_addr", imem.imem_addr, 32'h0);
        chk("rst_misaligned", 32'(target_misaligned), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        reset_n = 1'b1;
        tick();

        // Sequential zero-wait fetch: 0, 4, 8 (valid every 3 cycles)
        fetch(32'h0000_0000, 32'hA500_0013);
        fetch(32'h0000_0004, 32'hA500_0017);
        fetch(32'h0000_0008, 32'hA500_001B);

        // Redirect while waiting in RSP, response returned late
        chk("rsp_addr", imem.imem_addr, 32'h0000_000C);
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        pc_sel        = 1'b1;
        branch_target = 32'h0000_0100;
        #1;
        chk("rsp_flush_on", 32'(flush), 32'd1);
        tick();
        pc_sel = 1'b0;
        #1;
        chk("rsp_flush_off", 32'(flush), 32'd0);
        chk("rsp_wait_valid", 32'(inst_valid), 32'd0);
        chk("rsp_wait_req", 32'(imem.imem_req), 32'd0);
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem.imem_rvalid = 1'b0;
        chk("rsp_drop_valid", 32'(inst_valid), 32'd0);
        chk("rsp_new_req", 32'(imem.imem_req), 32'd1);
        chk("rsp_new_addr", imem.imem_addr, 32'h0000_0100);

        // Stall hold, then jump redirect
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hA500_0113;
        tick();
        imem.imem_rvalid = 1'b0;
        stall            = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_inst", inst, 32'hA500_0113);
            chk("hold_inst_pc", inst_pc, 32'h0000_0100);
            tick();
        end
        chk("hold_still_valid", 32'(inst_valid), 32'd1);
        jump        = 1'b1;
        jump_target = 32'h0000_0080;
        #1;
        chk("hold_flush", 32'(flush), 32'd1);
        tick();
        jump  = 1'b0;
        stall = 1'b0;
        chk("jump_valid_drop", 32'(inst_valid), 32'd0);
        chk("jump_req", 32'(imem.imem_req), 32'd1);
        chk("jump_addr", imem.imem_addr, 32'h0000_0080);
        chk("jump_aligned", 32'(target_misaligned), 32'd0);

        // Simultaneous branch and jump, misaligned branch target
        pc_sel        = 1'b1;
        branch_target = 32'h0000_0206;
        jump          = 1'b1;
        jump_target   = 32'h0000_0300;
        tick();
        pc_sel = 1'b0;
        jump   = 1'b0;
        chk("both_addr", imem.imem_addr, 32'h0000_0204);
        chk("both_misaligned_on", 32'(target_misaligned), 32'd1);
        tick();
        chk("both_misaligned_off", 32'(target_misaligned), 32'd0);

        // Slow grant: request held
        for (int i = 0; i < 3; i++) begin
            chk("slow_req", 32'(imem.imem_req), 32'd1);
            chk("slow_addr", imem.imem_addr, 32'h0000_0204);
            tick();
        end
        // Grant coincident with redirect
        imem.imem_gnt = 1'b1;
        pc_sel        = 1'b1;
        branch_target = 32'h0000_0040;
        tick();
        imem.imem_gnt = 1'b0;
        pc_sel        = 1'b0;
        chk("gntr_req", 32'(imem.imem_req), 32'd0);
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hA500_0217;
        tick();
        imem.imem_rvalid = 1'b0;
        chk("gntr_valid", 32'(inst_valid), 32'd0);
        chk("gntr_req2", 32'(imem.imem_req), 32'd1);
        chk("gntr_addr", imem.imem_addr, 32'h0000_0040);

        // Wrap at top of address space
        pc_sel        = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        pc_sel = 1'b0;
        fetch(32'hFFFF_FFFC, 32'h5AFF_FFEF);
        chk("wrap_addr", imem.imem_addr, 32'h0000_0000);

        // Async reset mid-RSP
        fetch(32'h0000_0000, 32'hA500_0013);
        chk("arst_pre_addr", imem.imem_addr, 32'h0000_0004);
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        chk("arst_in_rsp", 32'(imem.imem_req), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_addr", imem.imem_addr, 32'h0000_0000);
        #1;
        reset_n = 1'b1;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem.imem_rvalid = 1'b0;
        chk("stray_valid", 32'(inst_valid), 32'd0);
        chk("stray_req", 32'(imem.imem_req), 32'd1);
        chk("stray_addr", imem.imem_addr, 32'h0000_0000);
        fetch(32'h0000_0000, 32'hA500_0013);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
